// File: rtl/softlink_pkg.sv
// Shared constants for the softmax AXI-Lite stream bridge: register word indices,
// STATUS/CTRL bit positions, AXI response codes and the committed-write record.
package softlink_pkg;

    localparam int REG_TX_DATA = 0;
    localparam int REG_RX_DATA = 1;
    localparam int REG_STATUS  = 2;
    localparam int REG_CTRL    = 3;
    localparam int REG_VLEN    = 4;

    localparam int ST_TX_EMPTY = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_TX_OVF   = 4;
    localparam int ST_RX_UDF   = 5;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_TX_FLUSH = 1;
    localparam int CTRL_RX_FLUSH = 2;
    localparam int CTRL_CLR      = 3;
    localparam int CTRL_IRQ_EN   = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [2:0]  word;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_req_t;

endpackage

// File: rtl/softlink_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush; push is accepted when full
// if a pop happens in the same cycle.
module softlink_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = count_q;

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/softlink_axil_stream_bridge.sv
// AXI4-Lite slave feeding the softmax core through a TX FIFO and collecting its
// results through an RX FIFO, with status/control registers and TLAST framing.
module softlink_axil_stream_bridge
    import softlink_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   m_tdata,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic                            m_tlast,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_tdata,
    input  logic                            s_tvalid,
    output logic                            s_tready,
    output logic                            irq
);

    localparam int TXL = $clog2(TX_DEPTH) + 1;
    localparam int RXL = $clog2(RX_DEPTH) + 1;

    logic          aw_full_q, w_full_q, bvalid_q, rvalid_q;
    logic [2:0]    aw_word_q;
    logic [31:0]   w_data_q, rdata_q, rdata_d;
    logic [3:0]    w_strb_q;
    logic [1:0]    bresp_q, rresp_q, rresp_d;
    logic          ctrl_en_q, ctrl_irq_q, en_q, tx_ovf_q, rx_udf_q;
    logic [15:0]   vlen_q, cnt_q;
    logic          aw_hs, w_hs, ar_hs, commit;
    wr_req_t       wr;
    logic [2:0]    ar_word;
    logic          tx_push, tx_pop, tx_full, tx_empty, tx_err, tx_flush;
    logic          rx_push, rx_pop, rx_full, rx_empty, rx_udf_set, rx_flush;
    logic          ctrl_wr, vlen_wr, clr_sticky;
    logic [TXL-1:0] tx_level;
    logic [RXL-1:0] rx_level;
    logic [31:0]   tx_head, rx_head;
    logic          unused;

    assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

    assign S_AXI_AWREADY = !aw_full_q && !bvalid_q;
    assign S_AXI_WREADY  = !w_full_q && !bvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = !rvalid_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    // A beat handshaking this cycle completes the pair without waiting for the slot.
    assign commit = (aw_full_q || aw_hs) && (w_full_q || w_hs) && !bvalid_q;

    assign wr.word = aw_full_q ? aw_word_q : S_AXI_AWADDR[4:2];
    assign wr.data = w_full_q  ? w_data_q  : S_AXI_WDATA;
    assign wr.strb = w_full_q  ? w_strb_q  : S_AXI_WSTRB;
    assign ar_word = S_AXI_ARADDR[4:2];

    assign tx_pop     = m_tvalid && m_tready;
    assign tx_push    = commit && (wr.word == 3'(REG_TX_DATA)) && (wr.strb == 4'hF);
    assign tx_err     = commit && (wr.word == 3'(REG_TX_DATA)) && !(tx_push && (!tx_full || tx_pop));
    assign ctrl_wr    = commit && (wr.word == 3'(REG_CTRL)) && wr.strb[0];
    assign tx_flush   = ctrl_wr && wr.data[CTRL_TX_FLUSH];
    assign rx_flush   = ctrl_wr && wr.data[CTRL_RX_FLUSH];
    assign clr_sticky = ctrl_wr && wr.data[CTRL_CLR];
    assign vlen_wr    = commit && (wr.word == 3'(REG_VLEN));

    assign s_tready   = !rx_full;
    assign rx_push    = s_tvalid && s_tready;
    assign rx_pop     = ar_hs && (ar_word == 3'(REG_RX_DATA)) && !rx_empty;
    assign rx_udf_set = ar_hs && (ar_word == 3'(REG_RX_DATA)) && rx_empty;

    assign m_tvalid = en_q && !tx_empty;
    assign m_tdata  = tx_head;
    assign m_tlast  = (vlen_q != '0) && (cnt_q == vlen_q - 16'd1);
    assign irq      = ctrl_irq_q && !rx_empty;

    always_comb begin
        rdata_d = '0;
        rresp_d = RESP_OKAY;
        case (ar_word)
            3'(REG_RX_DATA): begin
                if (rx_empty) rresp_d = RESP_SLVERR;
                else          rdata_d = rx_head;
            end
            3'(REG_STATUS): begin
                rdata_d[ST_TX_EMPTY] = tx_empty;
                rdata_d[ST_TX_FULL]  = tx_full;
                rdata_d[ST_RX_EMPTY] = rx_empty;
                rdata_d[ST_RX_FULL]  = rx_full;
                rdata_d[ST_TX_OVF]   = tx_ovf_q;
                rdata_d[ST_RX_UDF]   = rx_udf_q;
                rdata_d[15:8]        = 8'(tx_level);
                rdata_d[23:16]       = 8'(rx_level);
            end
            3'(REG_CTRL): begin
                rdata_d[CTRL_EN]     = ctrl_en_q;
                rdata_d[CTRL_IRQ_EN] = ctrl_irq_q;
            end
            3'(REG_VLEN): rdata_d[15:0] = vlen_q;
            default: ;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            aw_word_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            ctrl_en_q  <= 1'b0;
            ctrl_irq_q <= 1'b0;
            en_q       <= 1'b0;
            tx_ovf_q   <= 1'b0;
            rx_udf_q   <= 1'b0;
            vlen_q     <= '0;
            cnt_q      <= '0;
        end else begin
            aw_full_q <= commit ? 1'b0 : (aw_full_q || aw_hs);
            w_full_q  <= commit ? 1'b0 : (w_full_q || w_hs);
            if (aw_hs) aw_word_q <= S_AXI_AWADDR[4:2];
            if (w_hs) begin
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= tx_err ? RESP_SLVERR : RESP_OKAY;
            end else if (S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
                rresp_q  <= rresp_d;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
            if (ctrl_wr) begin
                ctrl_en_q  <= wr.data[CTRL_EN];
                ctrl_irq_q <= wr.data[CTRL_IRQ_EN];
            end
            if (vlen_wr && wr.strb[0]) vlen_q[7:0]  <= wr.data[7:0];
            if (vlen_wr && wr.strb[1]) vlen_q[15:8] <= wr.data[15:8];
            // Enable changes only between beats so a presented word is never withdrawn.
            if (!m_tvalid || m_tready) en_q <= ctrl_en_q;
            tx_ovf_q <= (tx_ovf_q && !clr_sticky) || tx_err;
            rx_udf_q <= (rx_udf_q && !clr_sticky) || rx_udf_set;
            if (tx_flush || vlen_wr)  cnt_q <= '0;
            else if (tx_pop)          cnt_q <= m_tlast ? 16'd0 : cnt_q + 16'd1;
        end
    end

    softlink_sync_fifo #(.WIDTH(32), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (S_AXI_ACLK),
        .rst_n   (S_AXI_ARESETN),
        .flush_i (tx_flush),
        .push_i  (tx_push),
        .wdata_i (wr.data),
        .pop_i   (tx_pop),
        .rdata_o (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .level_o (tx_level)
    );

    softlink_sync_fifo #(.WIDTH(32), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (S_AXI_ACLK),
        .rst_n   (S_AXI_ARESETN),
        .flush_i (rx_flush),
        .push_i  (rx_push),
        .wdata_i (s_tdata),
        .pop_i   (rx_pop),
        .rdata_o (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .level_o (rx_level)
    );

endmodule
